// File: rtl/audio_fifo.sv
// Single-clock audio sample FIFO with level/threshold status, sticky error flags,
// synchronous flush and a selectable drop-or-overwrite policy when full.
module audio_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 64,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     clr_flags,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic full_w, empty_w;
    logic rd_ok, do_wr;

    assign full_w  = (level_q == LVL_W'(DEPTH));
    assign empty_w = (level_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        dout_d   = dout_q;
        dv_d     = 1'b0;
        ovf_d    = ovf_q & ~clr_flags;
        udf_d    = udf_q & ~clr_flags;
        rd_ok    = 1'b0;
        do_wr    = 1'b0;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            rd_ok = rd && !empty_w;
            if (rd && empty_w) begin
                udf_d = 1'b1;
            end
            if (rd_ok) begin
                dout_d   = mem_q[rd_ptr_q];
                dv_d     = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr) begin
                // A read in the same cycle frees a slot, so full only blocks a lone write
                if (full_w && !rd_ok) begin
                    ovf_d = 1'b1;
                    if (OVERWRITE != 0) begin
                        do_wr    = 1'b1;
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end else begin
                    do_wr = 1'b1;
                end
                if (do_wr) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
            if (do_wr && !rd_ok && !full_w) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_ok && !do_wr) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dv_q;
    assign level        = level_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (level_q >= LVL_W'(AF_THRESH));
    assign almost_empty = (level_q <= LVL_W'(AE_THRESH));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_audio_fifo.sv
// Bench for audio_fifo: drop (ow=0) and overwrite (ow=1) instances share stimulus
// and are each compared every cycle against a queue-based reference.
module tb_audio_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AF    = 60;
    localparam int AE    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0, clr_flags = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [WIDTH-1:0] din = '0;

    logic [WIDTH-1:0] dout_w [2];
    logic             dv_w [2], full_w [2], empty_w [2], af_w [2], ae_w [2];
    logic             ovf_w [2], udf_w [2];
    logic [6:0]       level_w [2];

    // reference state
    logic [WIDTH-1:0] mq [2][$];
    logic [WIDTH-1:0] e_dout [2];
    logic             e_dv [2], e_ovf [2], e_udf [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    audio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .OVERWRITE(0)) u_drop (
        .clk(clk), .rst(rst), .flush(flush), .clr_flags(clr_flags),
        .wr(wr), .din(din), .rd(rd),
        .dout(dout_w[0]), .dout_valid(dv_w[0]), .full(full_w[0]), .empty(empty_w[0]),
        .almost_full(af_w[0]), .almost_empty(ae_w[0]), .level(level_w[0]),
        .overflow(ovf_w[0]), .underflow(udf_w[0])
    );

    audio_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .OVERWRITE(1)) u_ovw (
        .clk(clk), .rst(rst), .flush(flush), .clr_flags(clr_flags),
        .wr(wr), .din(din), .rd(rd),
        .dout(dout_w[1]), .dout_valid(dv_w[1]), .full(full_w[1]), .empty(empty_w[1]),
        .almost_full(af_w[1]), .almost_empty(ae_w[1]), .level(level_w[1]),
        .overflow(ovf_w[1]), .underflow(udf_w[1])
    );

    task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ow=%0d observed=%0h expected=%0h", tag, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            e_dout[m] = '0;
            e_dv[m]   = 1'b0;
            e_ovf[m]  = 1'b0;
            e_udf[m]  = 1'b0;
        end
    endtask

    task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                              input logic f, input logic c);
        for (int m = 0; m < 2; m++) begin
            int  sz;
            bit  took, ovf_ev, udf_ev;
            sz = mq[m].size();
            ovf_ev = 0;
            udf_ev = 0;
            if (f) begin
                mq[m].delete();
                e_dv[m] = 1'b0;
            end else begin
                took = r && (sz > 0);
                if (r && sz == 0) udf_ev = 1;
                if (took) begin
                    e_dout[m] = mq[m].pop_front();
                    e_dv[m]   = 1'b1;
                end else begin
                    e_dv[m] = 1'b0;
                end
                if (w) begin
                    if (sz == DEPTH && !took) begin
                        ovf_ev = 1;
                        if (m == 1) begin
                            void'(mq[m].pop_front());
                            mq[m].push_back(d);
                        end
                    end else begin
                        mq[m].push_back(d);
                    end
                end
            end
            e_ovf[m] = ovf_ev | (e_ovf[m] & ~c);
            e_udf[m] = udf_ev | (e_udf[m] & ~c);
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            int lvl;
            lvl = mq[m].size();
            chk("level", m, 32'(level_w[m]), 32'(lvl));
            chk("full", m, 32'(full_w[m]), 32'(lvl == DEPTH));
            chk("empty", m, 32'(empty_w[m]), 32'(lvl == 0));
            chk("almost_full", m, 32'(af_w[m]), 32'(lvl >= AF));
            chk("almost_empty", m, 32'(ae_w[m]), 32'(lvl <= AE));
            chk("dout_valid", m, 32'(dv_w[m]), 32'(e_dv[m]));
            chk("dout", m, 32'(dout_w[m]), 32'(e_dout[m]));
            chk("overflow", m, 32'(ovf_w[m]), 32'(e_ovf[m]));
            chk("underflow", m, 32'(udf_w[m]), 32'(e_udf[m]));
        end
    endtask

    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic f, input logic c);
        wr = w; din = d; rd = r; flush = f; clr_flags = c;
        @(posedge clk);
        model_step(w, d, r, f, c);
        #1;
        compare_all();
    endtask

    task automatic idle();
        wr = 0; rd = 0; flush = 0; clr_flags = 0;
    endtask

    initial begin
        model_reset();
        #2;
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // 1: basic in-order traffic
        for (int i = 1; i <= 20; i++) step(1, 16'(i), 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 1, 0, 0);
            chk("p1_dout", 0, 32'(dout_w[0]), 32'(i));
            step(0, 0, 0, 0, 0);
        end

        // 2/3: overflow in both policies, then underflow, then clear
        for (int i = 21; i <= 88; i++) step(1, 16'(i), 0, 0, 0);
        chk("p2_level", 0, 32'(level_w[0]), 32'd64);
        for (int i = 0; i < 65; i++) step(0, 0, 1, 0, 0);
        chk("p2_dout_hold", 0, 32'(dout_w[0]), 32'd84);
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 70; i++) step(1, 16'(i), 0, 0, 0);
        chk("p3_level", 1, 32'(level_w[1]), 32'd64);
        step(0, 0, 1, 0, 0);
        chk("p3_first", 1, 32'(dout_w[1]), 32'd7);
        for (int i = 1; i < 64; i++) step(0, 0, 1, 0, 0);
        chk("p3_last", 1, 32'(dout_w[1]), 32'd70);
        step(0, 0, 0, 0, 1);

        // 4: simultaneous rd+wr at full, then at empty
        for (int i = 1; i <= 64; i++) step(1, 16'(i), 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 16'(100 + i), 1, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0);
        chk("p4_tail", 0, 32'(dout_w[0]), 32'd109);
        step(1, 16'd5, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("p4_empty_rw", 0, 32'(dout_w[0]), 32'd5);
        step(0, 0, 0, 0, 1);

        // 5: threshold walk
        for (int i = 0; i < 60; i++) step(1, 16'($urandom), 0, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 0, 1, 0, 0);

        // 6: flush beats rd/wr, async reset mid-stream, first op after release
        for (int i = 0; i < 10; i++) step(1, 16'(200 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 16'hBEEF, 1, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 16'(300 + i), 0, 0, 0);
        idle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        step(1, 16'd7, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("p6_after_rst", 0, 32'(dout_w[0]), 32'd7);

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 1200; i++) begin
            logic w, r, f, c;
            bit fill;
            fill = ((i / 150) % 2) == 0;
            w = fill ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            r = fill ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            f = ($urandom_range(0, 99) == 0);
            c = ($urandom_range(0, 31) == 0);
            step(w, 16'($urandom), r, f, c);
        end

        idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_fifo.md
Name: audio_fifo

Overview:
Parametrised single-clock sample FIFO for audio paths, such as a codec interface to a mixer or an effects chain to an output stage.
- Adds status outputs to the basic rd/wr buffer: full, empty, almost thresholds and fill level.
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Overflow policy is selectable: drop the incoming sample, or overwrite the oldest sample to keep latency bounded.

Parameters:
WIDTH, 16, sample width in bits
DEPTH, 64, number of entries; power of 2, >= 4
AF_THRESH, DEPTH-4, almost_full asserts when level >= AF_THRESH
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH
OVERWRITE, 0, 0 = drop write when full; 1 = overwrite oldest entry when full

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous empty request
clr_flags  in  1  clears sticky overflow/underflow
wr  in  1  write strobe, one sample per cycle high
din  in  WIDTH  write data
rd  in  1  read strobe, one sample per cycle high
dout  out  WIDTH  read data (registered)
dout_valid  out  1  one-cycle pulse; dout holds a newly read sample
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write hit a full FIFO
underflow  out  1  sticky: a read hit an empty FIFO

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, level, dout, dout_valid, overflow and underflow go to 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are don't-care.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is a separate registered counter.
- full, empty, almost_full and almost_empty are combinational decodes of the level register. They change the cycle after the edge that changes level.
- Read:
  - rd high and not empty at an edge: dout <= mem[rd_ptr], rd_ptr+1, level-1, dout_valid = 1 for the following cycle.
  - dout holds its value until the next successful read.
  - No fall-through: a sample written at edge N is readable at edge N+1 at the earliest.
- Read when empty: no state change, dout_valid = 0, underflow <= 1.
- Write when not full: mem[wr_ptr] <= din, wr_ptr+1, level+1.
- Write when full:
  - OVERWRITE=0: data dropped, pointers and level unchanged, overflow <= 1.
  - OVERWRITE=1: mem[wr_ptr] <= din, wr_ptr+1, rd_ptr+1 (oldest discarded), level stays DEPTH, overflow <= 1.
- Simultaneous rd and wr:
  - Not empty, not full: both execute, level unchanged.
  - Empty: the write executes; the read counts as an underflow (underflow <= 1, dout_valid = 0); level becomes 1.
  - Full (either mode): read then write both execute, level stays DEPTH, no overflow.
- flush:
  - Has priority over rd and wr in the same cycle.
  - Pointers and level go to 0, dout_valid = 0, dout is retained.
  - overflow/underflow are unaffected.
- clr_flags clears overflow/underflow. If an error event occurs in the same cycle, set wins.
- Reset asserted mid-burst aborts immediately. The first operation after release is accepted on the first edge with rst high.

Test Plan:
(bench: WIDTH=16, DEPTH=64, AF=60, AE=4 unless noted)
1. Write 1..20 on separate cycles, then 20 single-cycle rd pulses -> dout 1..20 in order, each with a one-cycle dout_valid the cycle after rd; level 20 -> 0; empty = 1 at the end; no flags set.
2. OVERWRITE=0: write 21..88 back-to-back -> full after the 64th write, level = 64, overflow = 1; 64 reads return 21..84; the 65th read leaves dout = 84, dout_valid = 0, underflow = 1; clr_flags clears both flags.
3. OVERWRITE=1: write 1..70 back-to-back -> level = 64, overflow = 1; 64 reads return 7..70, proving rd_ptr advances on overwrite and the pointers wrap.
4. Fill to 64, then 10 cycles of simultaneous rd+wr with din = 100..109 -> level stays 64, overflow stays 0; reads return 1..10; the remaining reads return 11..64 then 100..109. Also on an empty FIFO, rd+wr of 5 -> underflow = 1, level = 1, and the next read returns 5.
5. Threshold walk: write to 60 -> almost_full rises exactly when level = 60; read down to 4 -> almost_empty rises at level = 4, empty rises at 0.
6. With 10 words stored:
   - Assert flush together with rd and wr -> level = 0, empty = 1, dout_valid = 0, dout unchanged.
   - Refill with 10 words, then drive rst low between edges -> all outputs reach reset values before the next edge.
   - Write 7 after release -> the first read returns 7.
